path_dir_packer: RTL and testbench
==================================

Name: path_dir_packer

Overview:
- Responder end of the path-planner handshake.
- Accepts a stream of 2-bit direction codes from the planner's backtrack stage and packs them LSB-first into a flat direction vector, terminated by a 00 slot.
- On a start request it clears, collects the codes, then raises done with final_path stable.
- Its consumers step through final_path two bits at a time until they reach a 00 slot.

Parameters:
- MAX_STEPS, 10: slots in final_path. The last slot is always 00, so at most MAX_STEPS-1 directions are stored.
- DIR_W, 2: bits per direction code.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  synchronous active-low reset
- start  in  1  request level; a rising edge begins a new packing job
- in_valid  in  1  direction code valid
- in_dir  in  DIR_W  direction code: 01 straight, 10 left, 11 right, 00 end
- in_last  in  1  marks the final code of the job; qualified by in_valid
- in_ready  out  1  packer accepts in_dir this cycle
- done  out  1  final_path complete and stable
- final_path  out  MAX_STEPS*DIR_W  packed directions; slot k is at bits [2k+1:2k]
- step_count  out  $clog2(MAX_STEPS)  number of directions stored
- overflow  out  1  codes were dropped because capacity was exceeded

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, final_path=0, done=0, in_ready=0, step_count=0, overflow=0, start_d=0.
- Start detection: start is registered into start_d. A job begins on the cycle start=1 and start_d=0. Holding start high for many cycles starts only one job.
- IDLE: in_ready=0. On a start edge go to CLEAR.
- CLEAR (1 cycle):
  - final_path=0, step_count=0, overflow=0, done=0.
  - Go to COLLECT.
- COLLECT: in_ready=1. A beat is accepted when in_valid and in_ready are both 1.
  - Accepted in_dir!=00 with step_count<MAX_STEPS-1: write slot[step_count], then step_count+1.
  - Accepted in_dir!=00 with step_count==MAX_STEPS-1: code dropped; overflow=1 (sticky until the next CLEAR).
  - Accepted in_dir==00: ends the job; the code is not written.
  - Accepted in_last=1: the code is handled as above, then the job ends.
  - Job end goes to FINISH; in_ready drops the following cycle.
- FINISH (1 cycle): done=1, then go to DONE.
- DONE:
  - done stays 1 and final_path is held; in_ready=0.
  - A new start edge goes to CLEAR, which drops done the next cycle.
- Start edge while in COLLECT: abort the job and go to CLEAR. Partial data is discarded and done is not raised.
- Latency: done rises 2 cycles after the accepted last beat (1 cycle to FINISH, 1 cycle to DONE).
- Slot MAX_STEPS-1 is always 00, so consumers always terminate.
- A zero-length job (first beat is in_dir=00) completes with final_path=0, step_count=0, done=1.
- rst_n low in any state returns to the reset values on that edge; reset overrides a start edge.

Optional Feature:
- Macro: PATH_REVERSE_EN.
- Defined:
  - The planner delivers codes in backtrack order (goal to source).
  - FINISH becomes a 1-cycle REVERSE step that maps slot k to slot step_count-1-k for k<step_count, keeping 00 slots above step_count.
  - done rises in the cycle after REVERSE, so latency is still 2 cycles.
- Undefined: slots stay in arrival order.

Decomposition:
- Shared package path_pkg holds:
  - DIR_END=2'b00, DIR_STRAIGHT=2'b01, DIR_LEFT=2'b10, DIR_RIGHT=2'b11
  - default MAX_STEPS=10 and DIR_W=2
  - state encodings IDLE/CLEAR/COLLECT/FINISH/DONE
- One sub-module, edge_detect_rise: registered rising-edge pulse with synchronous active-low reset. It is reused by the consumer side.

Test Plan:
- Reset with rst_n=0, then pulse start, send 01,10,11 with in_last on 11 -> done=1 two cycles later, final_path=20'h00039, step_count=3, overflow=0.
- Hold start high 200 cycles, send 10 with in_last -> exactly one job; final_path=20'h00002; done stays 1 until the next start edge.
- Send 12 codes of 01 -> first 9 stored, final_path=20'h15555 with slot 9=00, step_count=9, overflow=1.
- First beat in_dir=00 -> done=1, final_path=0, step_count=0.
- Send 01,01, then a new start edge mid-COLLECT, then 11 with in_last -> final_path=20'h00003; no done pulse between the two jobs.
- With PATH_REVERSE_EN, send 01,10,11 -> final_path=20'h0001B. Also assert rst_n=0 while in DONE -> all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/path_pkg.sv
// ============================================================================
// Module  : path_pkg
// Brief   : Shared direction codes, default sizes and packer state encodings.
// Revision: 1.0
// ============================================================================
`default_nettype none

package path_pkg;

  localparam logic [1:0] DIR_END      = 2'b00;
  localparam logic [1:0] DIR_STRAIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT     = 2'b10;
  localparam logic [1:0] DIR_RIGHT    = 2'b11;

  localparam int DEF_MAX_STEPS = 10;
  localparam int DEF_DIR_W     = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] CLEAR   = 3'd1;
  localparam logic [STATE_W-1:0] COLLECT = 3'd2;
  localparam logic [STATE_W-1:0] FINISH  = 3'd3;
  localparam logic [STATE_W-1:0] DONE    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/edge_detect_rise.sv
// ============================================================================
// Module  : edge_detect_rise
// Brief   : Rising-edge pulse against a registered copy of the input level.
// Revision: 1.0
// ============================================================================
`default_nettype none

module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic r_din_d;

  always_ff @(posedge clk) begin
    if (!rst_n) r_din_d <= 1'b0;
    else        r_din_d <= din;
  end

  assign pulse = din & ~r_din_d;

endmodule

`default_nettype wire

// File: rtl/path_dir_packer.sv
// ============================================================================
// Module  : path_dir_packer
// Brief   : Packs planner direction codes LSB-first into a 00-terminated vector.
//           Optional macro PATH_REVERSE_EN reverses the stored order at finish.
// Revision: 1.0
// ============================================================================
`default_nettype none

module path_dir_packer
  import path_pkg::*;
#(
  parameter int MAX_STEPS = DEF_MAX_STEPS,
  parameter int DIR_W     = DEF_DIR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DIR_W-1:0]              in_dir,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          done,
  output logic [MAX_STEPS*DIR_W-1:0]    final_path,
  output logic [$clog2(MAX_STEPS)-1:0]  step_count,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(MAX_STEPS);
  localparam logic [CNT_W-1:0] c_LAST_SLOT = CNT_W'(MAX_STEPS - 1);

  logic [STATE_W-1:0]         r_state;
  logic [STATE_W-1:0]         w_next;
  logic                       w_start_edge;
  logic                       w_accept;
  logic                       w_is_end;
  logic                       w_job_end;
  logic [MAX_STEPS*DIR_W-1:0] r_path;
  logic [CNT_W-1:0]           r_step_count;
  logic                       r_overflow;

  edge_detect_rise u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (start),
    .pulse (w_start_edge)
  );

  assign w_accept  = in_valid & in_ready;
  assign w_is_end  = (in_dir == DIR_W'(DIR_END));
  assign w_job_end = w_accept & (w_is_end | in_last);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_next = CLEAR;
      CLEAR:   w_next = COLLECT;
      COLLECT: begin
        // A fresh start edge aborts the running job even if a beat is accepted.
        if (w_start_edge)   w_next = CLEAR;
        else if (w_job_end) w_next = FINISH;
      end
      FINISH:  w_next = DONE;
      DONE:    if (w_start_edge) w_next = CLEAR;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (r_state)
      COLLECT: in_ready = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

`ifdef PATH_REVERSE_EN
  logic [MAX_STEPS*DIR_W-1:0] w_rev_path;

  always_comb begin
    w_rev_path = '0;
    for (int k = 0; k < MAX_STEPS; k++) begin
      if (k < int'(r_step_count))
        w_rev_path[k*DIR_W +: DIR_W] = r_path[(int'(r_step_count) - 1 - k)*DIR_W +: DIR_W];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_path       <= '0;
      r_step_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_path       <= '0;
          r_step_count <= '0;
          r_overflow   <= 1'b0;
        end
        COLLECT: begin
          if (w_accept && !w_start_edge && !w_is_end) begin
            // The top slot is never written so the vector stays 00-terminated.
            if (r_step_count < c_LAST_SLOT) begin
              r_path[r_step_count*DIR_W +: DIR_W] <= in_dir;
              r_step_count <= r_step_count + 1'b1;
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end
        FINISH: begin
`ifdef PATH_REVERSE_EN
          r_path <= w_rev_path;
`endif
        end
        default: ;
      endcase
    end
  end

  assign final_path = r_path;
  assign step_count = r_step_count;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_path_dir_packer.sv
// ============================================================================
// Module  : tb_path_dir_packer
// Brief   : Directed plus randomized jobs checked against a list-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_path_dir_packer;

  localparam int MS = 10;
  localparam int DW = 2;
  localparam int CW = $clog2(MS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [DW-1:0]     in_dir;
  logic              in_last;
  wire               in_ready;
  wire               done;
  wire  [MS*DW-1:0]  final_path;
  wire  [CW-1:0]     step_count;
  wire               overflow;

  int n_cmp = 0;
  int n_bad = 0;

  path_dir_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_dir     (in_dir),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .done       (done),
    .final_path (final_path),
    .step_count (step_count),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the code list, stop at the first 00, keep at most MS-1 codes.
  function automatic void model(input logic [1:0] codes[$], output logic [MS*DW-1:0] path,
                                output int cnt, output logic ovf);
    int stored[$];
    ovf = 1'b0;
    foreach (codes[i]) begin
      if (codes[i] == 2'b00) break;
      if (stored.size() < MS - 1) stored.push_back(int'(codes[i]));
      else ovf = 1'b1;
    end
    cnt  = stored.size();
    path = '0;
    for (int i = 0; i < cnt; i++) begin
`ifdef PATH_REVERSE_EN
      path = path | ((MS*DW)'(stored[cnt-1-i]) << (2*i));
`else
      path = path | ((MS*DW)'(stored[i]) << (2*i));
`endif
    end
  endfunction

  // Present each code (in_last on the final one), then check the finish timing and result.
  task automatic send_and_finish(input logic [1:0] codes[$], input bit gaps);
    logic [MS*DW-1:0] e_path;
    int               e_cnt;
    logic             e_ovf;
    foreach (codes[i]) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_dir   = 2'($urandom);
          in_last  = 1'($urandom);
          chk("ready_idle", 32'(in_ready), 32'd1);
          tick();
        end
      end
      in_valid = 1'b1;
      in_dir   = codes[i];
      in_last  = (i == codes.size() - 1);
      chk("ready_beat", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("finish_ready", 32'(in_ready), 32'd0);
    chk("finish_done", 32'(done), 32'd0);
    tick();
    model(codes, e_path, e_cnt, e_ovf);
    chk("done", 32'(done), 32'd1);
    chk("final_path", 32'(final_path), 32'(e_path));
    chk("step_count", 32'(step_count), 32'(e_cnt));
    chk("overflow", 32'(overflow), 32'(e_ovf));
  endtask

  task automatic run_job(input logic [1:0] codes[$], input bit hold, input bit gaps);
    start = 1'b1;
    tick();
    chk("clear_done", 32'(done), 32'd0);
    chk("clear_ready", 32'(in_ready), 32'd0);
    if (!hold) start = 1'b0;
    tick();
    send_and_finish(codes, gaps);
  endtask

  initial begin
    logic [1:0] q[$];
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_dir   = '0;
    in_last  = 1'b0;
    tick();
    tick();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_path", 32'(final_path), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic three-code job.
    q = '{2'b01, 2'b10, 2'b11};
    run_job(q, 1'b0, 1'b0);

    // Start held high: one job only, done holds throughout.
    q = '{2'b10};
    run_job(q, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    chk("hold_path", 32'(final_path), 32'h00002);
    start = 1'b0;
    tick();

    // Capacity overflow.
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(2'b01);
    run_job(q, 1'b0, 1'b0);

    // Zero-length job.
    q = '{2'b00};
    run_job(q, 1'b0, 1'b0);

    // Abort mid-collect with a new start edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_dir   = 2'b01;
      in_last  = 1'b0;
      chk("abort_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready_clr", 32'(in_ready), 32'd0);
    start = 1'b0;
    tick();
    chk("abort_done2", 32'(done), 32'd0);
    q = '{2'b11};
    send_and_finish(q, 1'b0);

    // Randomized jobs with gaps, ended by in_last or a 00 code.
    for (int j = 0; j < 12; j++) begin
      int len;
      len = $urandom_range(1, 13);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(2'($urandom_range(1, 3)));
      if ($urandom_range(0, 1) == 1) q[len-1] = 2'b00;
      run_job(q, 1'b0, 1'b1);
    end

    // Reset while in DONE.
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk("rstd_done", 32'(done), 32'd0);
    chk("rstd_ready", 32'(in_ready), 32'd0);
    chk("rstd_path", 32'(final_path), 32'd0);
    chk("rstd_count", 32'(step_count), 32'd0);
    chk("rstd_ovf", 32'(overflow), 32'd0);
    // Reset overrode the start edge, so the packer must still be idle.
    tick();
    chk("rstd_idle", 32'(in_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
